// File: rtl/hall_commutation_ctrl.sv
// -----------------------------------------------------------------------------
// hall_commutation_ctrl
//
// Per-axis BLDC commutation stage. Takes the raw hall conduit, synchronises and
// debounces it, decodes the 120-degree sector, and measures the commutation
// period for the velocity loop. Drives the six gate signals with high-side PWM
// chopping and enforced dead-time, and latches the gate driver nFAULT.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable synced cycles before a hall change is
//                    accepted (>= 1)
//   DEADTIME_CYCLES  gate turn-on delay in clk cycles (>= 1)
//   PERIOD_W         width of the commutation period counter
//
// Ports:
//   clk            system clock
//   reset_n        synchronous active-low reset
//   hall[2:0]      raw hall inputs {C,B,A}, asynchronous
//   nfault         gate driver nFAULT, active low, asynchronous
//   enable         software motor enable
//   dir            0 = forward, 1 = reverse
//   pwm_in         duty-modulated PWM, synchronous to clk
//   clear_fault    single-cycle pulse, clears the latched fault
//   phase[5:0]     gate drives {AH,AL,BH,BL,CH,CL}, active high
//   drv_en         gate driver enable
//   sector[2:0]    decoded sector 0..5
//   sector_valid   current debounced hall code is legal
//   hall_err       single-cycle pulse on illegal code or non-adjacent jump
//   period         clk cycles between the last two valid adjacent transitions
//   period_valid   single-cycle pulse when period updates
//   fault_latched  sticky fault flag
// -----------------------------------------------------------------------------
module hall_commutation_ctrl #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int DEADTIME_CYCLES = 50,
    parameter int PERIOD_W        = 24
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [2:0]          hall,
    input  logic                nfault,
    input  logic                enable,
    input  logic                dir,
    input  logic                pwm_in,
    input  logic                clear_fault,
    output logic [5:0]          phase,
    output logic                drv_en,
    output logic [2:0]          sector,
    output logic                sector_valid,
    output logic                hall_err,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                fault_latched
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DTW = $clog2(DEADTIME_CYCLES + 1);
    localparam logic [DBW-1:0] DB_MAX  = DBW'(DEBOUNCE_CYCLES);
    localparam logic [DTW-1:0] DT_LOAD = DTW'(DEADTIME_CYCLES);

    typedef enum logic {
        RUN,
        DEAD
    } dt_state_t;

    // -------------------------------------------------------------------------
    // Two-flop synchronisers
    // -------------------------------------------------------------------------
    logic [2:0] hall_s1;
    logic [2:0] hall_s2;
    logic       nfault_s1;
    logic       nfault_s2;

    // nfault synchroniser resets to the inactive (high) level so that leaving
    // reset does not latch a phantom fault.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hall_s1   <= '0;
            hall_s2   <= '0;
            nfault_s1 <= 1'b1;
            nfault_s2 <= 1'b1;
        end else begin
            hall_s1   <= hall;
            hall_s2   <= hall_s1;
            nfault_s1 <= nfault;
            nfault_s2 <= nfault_s1;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce
    // hall_prev is the synced code one cycle ago; db_next is the run length of
    // the current synced code including this cycle.
    // -------------------------------------------------------------------------
    logic [2:0]     hall_prev;
    logic [2:0]     stable;
    logic [DBW-1:0] db_cnt;
    logic [DBW-1:0] db_next;

    always_comb begin
        db_next = DBW'(1);
        if (hall_s2 == hall_prev) begin
            db_next = db_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hall_prev <= '0;
            stable    <= '0;
            db_cnt    <= '0;
        end else begin
            hall_prev <= hall_s2;
            if (hall_s2 == stable) begin
                db_cnt <= '0;
            end else if (db_next >= DB_MAX) begin
                stable <= hall_s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_next;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sector decode {C,B,A}: 001->0 011->1 010->2 110->3 100->4 101->5
    // -------------------------------------------------------------------------
    logic       dec_legal;
    logic [2:0] dec_sec;
    logic [2:0] sec_up;
    logic [2:0] sec_dn;
    logic       adjacent;

    always_comb begin
        dec_legal = 1'b1;
        dec_sec   = 3'd0;
        case (stable)
            3'b001:  dec_sec = 3'd0;
            3'b011:  dec_sec = 3'd1;
            3'b010:  dec_sec = 3'd2;
            3'b110:  dec_sec = 3'd3;
            3'b100:  dec_sec = 3'd4;
            3'b101:  dec_sec = 3'd5;
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        sec_up   = (sector == 3'd5) ? 3'd0 : sector + 3'd1;
        sec_dn   = (sector == 3'd0) ? 3'd5 : sector - 3'd1;
        adjacent = (dec_sec == sec_up) || (dec_sec == sec_dn);
    end

    // -------------------------------------------------------------------------
    // Sector register, transition check and period measurement.
    // code_q is the stable code the sector outputs were last computed from;
    // a mismatch marks a newly accepted code. sector_valid doubles as
    // "a previous legal sector exists" for the adjacency test.
    // -------------------------------------------------------------------------
    logic [2:0]          code_q;
    logic [PERIOD_W-1:0] per_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            code_q       <= '0;
            sector       <= '0;
            sector_valid <= 1'b0;
            hall_err     <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            per_cnt      <= '0;
        end else begin
            hall_err     <= 1'b0;
            period_valid <= 1'b0;
            if (per_cnt != '1) begin
                per_cnt <= per_cnt + 1'b1;
            end
            if (stable != code_q) begin
                code_q <= stable;
                if (dec_legal) begin
                    sector       <= dec_sec;
                    sector_valid <= 1'b1;
                    per_cnt      <= PERIOD_W'(1);
                    if (sector_valid) begin
                        if (adjacent) begin
                            period       <= per_cnt;
                            period_valid <= 1'b1;
                        end else begin
                            hall_err <= 1'b1;
                        end
                    end
                end else begin
                    sector_valid <= 1'b0;
                    if (sector_valid) begin
                        hall_err <= 1'b1;
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Commutation target from the effective sector
    // -------------------------------------------------------------------------
    logic [2:0] eff;
    logic [5:0] target;

    always_comb begin
        eff = sector;
        if (dir) begin
            eff = (sector >= 3'd3) ? sector - 3'd3 : sector + 3'd3;
        end
    end

    always_comb begin
        target = '0;
        case (eff)
            3'd0:    target = {pwm_in, 1'b0, 1'b0,   1'b1, 1'b0,   1'b0}; // AH,BL
            3'd1:    target = {pwm_in, 1'b0, 1'b0,   1'b0, 1'b0,   1'b1}; // AH,CL
            3'd2:    target = {1'b0,   1'b0, pwm_in, 1'b0, 1'b0,   1'b1}; // BH,CL
            3'd3:    target = {1'b0,   1'b1, pwm_in, 1'b0, 1'b0,   1'b0}; // BH,AL
            3'd4:    target = {1'b0,   1'b1, 1'b0,   1'b0, pwm_in, 1'b0}; // CH,AL
            3'd5:    target = {1'b0,   1'b0, 1'b0,   1'b1, pwm_in, 1'b0}; // CH,BL
            default: target = '0;
        endcase
        if (!sector_valid || !enable || fault_latched) begin
            target = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Dead-time FSM and fault latch
    // A turn-on is loaded on the edge that first sees it and completes
    // DEADTIME_CYCLES edges later, so every gate-off to gate-on gap is at least
    // DEADTIME_CYCLES. Any target change while waiting restarts the wait.
    // -------------------------------------------------------------------------
    dt_state_t      state;
    logic [DTW-1:0] dcnt;
    logic [5:0]     target_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= RUN;
            dcnt          <= '0;
            phase         <= '0;
            target_q      <= '0;
            fault_latched <= 1'b0;
            drv_en        <= 1'b0;
        end else begin
            target_q <= target;
            drv_en   <= enable & ~fault_latched;
            if (!nfault_s2) begin
                fault_latched <= 1'b1;
                phase         <= '0;
                state         <= RUN;
                dcnt          <= '0;
            end else begin
                if (clear_fault) begin
                    fault_latched <= 1'b0;
                end
                case (state)
                    RUN: begin
                        if (target != phase) begin
                            if ((target & ~phase) == '0) begin
                                phase <= target;
                            end else begin
                                phase <= phase & target;
                                dcnt  <= DT_LOAD;
                                state <= DEAD;
                            end
                        end
                    end
                    DEAD: begin
                        phase <= phase & target;
                        if (target != target_q) begin
                            dcnt <= DT_LOAD;
                        end else if (dcnt <= DTW'(1)) begin
                            phase <= target;
                            dcnt  <= '0;
                            state <= RUN;
                        end else begin
                            dcnt <= dcnt - 1'b1;
                        end
                    end
                    default: begin
                        phase <= '0;
                        state <= RUN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hall_commutation_ctrl.sv
module tb_hall_commutation_ctrl;

    localparam int DB  = 8;
    localparam int DT  = 50;
    localparam int PW  = 10;
    localparam int SAT = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [2:0]    hall;
    logic          nfault;
    logic          enable;
    logic          dir;
    logic          pwm_in;
    logic          clear_fault;
    logic [5:0]    phase;
    logic          drv_en;
    logic [2:0]    sector;
    logic          sector_valid;
    logic          hall_err;
    logic [PW-1:0] period;
    logic          period_valid;
    logic          fault_latched;

    always #5 clk = ~clk;

    hall_commutation_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .DEADTIME_CYCLES(DT),
        .PERIOD_W(PW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .hall(hall),
        .nfault(nfault),
        .enable(enable),
        .dir(dir),
        .pwm_in(pwm_in),
        .clear_fault(clear_fault),
        .phase(phase),
        .drv_en(drv_en),
        .sector(sector),
        .sector_valid(sector_valid),
        .hall_err(hall_err),
        .period(period),
        .period_valid(period_valid),
        .fault_latched(fault_latched)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Expected hall-side output events
    typedef struct {
        int cyc;
        int sec;
        int valid;
        int err;
        int pv;
        int per;
    } ev_t;
    ev_t sb[$];

    // Reference model: hall code -> sector (-1 = illegal)
    int sec_of[8] = '{-1, 0, 2, 1, 4, 5, 3, -1};
    int m_code     = 0;
    int m_sec      = 0;
    int m_valid    = 0;
    int m_last_acc = 0;
    int m_per      = 0;

    // A code presented on the pin right after edge t0 and held long enough
    // shows up on the sector outputs at edge t0 + DB + 3.
    task automatic model_apply(input int code, input int t0);
        int  tacc;
        int  s;
        int  d;
        ev_t e;
        tacc = t0 + DB + 3;
        s    = sec_of[code];
        if (code == m_code) return;
        m_code = code;
        e.cyc = tacc;
        e.err = 0;
        e.pv  = 0;
        if (s < 0) begin
            if (m_valid != 0) begin
                m_valid = 0;
                e.sec   = m_sec;
                e.valid = 0;
                e.err   = 1;
                e.per   = m_per;
                sb.push_back(e);
            end
        end else begin
            if (m_valid != 0) begin
                d = (s - m_sec + 6) % 6;
                if (d == 1 || d == 5) begin
                    m_per = (tacc - m_last_acc > SAT) ? SAT : tacc - m_last_acc;
                    e.pv  = 1;
                end else begin
                    e.err = 1;
                end
            end
            m_sec      = s;
            m_valid    = 1;
            m_last_acc = tacc;
            e.sec      = s;
            e.valid    = 1;
            e.per      = m_per;
            sb.push_back(e);
        end
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got 0x%0h want 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_hall(input int code);
        hall = 3'(code);
        model_apply(code, cyc);
    endtask

    // Scoreboard monitor: any hall-side output activity pops one expectation
    bit       mon_en  = 1'b0;
    bit [3:0] prev_sv = '0;
    ev_t      got;
    always @(negedge clk) begin
        if (mon_en) begin
            if (period_valid || hall_err || {sector, sector_valid} != prev_sv) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event cycle=%0d sector=%0d valid=%0b err=%0b pv=%0b period=%0d",
                             cyc, sector, sector_valid, hall_err, period_valid, period);
                end else begin
                    got = sb.pop_front();
                    if (cyc != got.cyc || int'(sector) != got.sec || int'(sector_valid) != got.valid ||
                        int'(hall_err) != got.err || int'(period_valid) != got.pv || int'(period) != got.per) begin
                        bad++;
                        $display("FAIL hall_event got cyc=%0d sec=%0d v=%0b err=%0b pv=%0b per=%0d want cyc=%0d sec=%0d v=%0d err=%0d pv=%0d per=%0d",
                                 cyc, sector, sector_valid, hall_err, period_valid, period,
                                 got.cyc, got.sec, got.valid, got.err, got.pv, got.per);
                    end
                end
            end
            prev_sv = {sector, sector_valid};
        end
    end

    // Gate monitor: no leg shoot-through, and every turn-on at least DT
    // cycles after that gate's previous change
    bit [5:0] prev_phase = '0;
    int       last_chg[6] = '{default: 0};
    always @(negedge clk) begin
        total++;
        if ((phase[5] && phase[4]) || (phase[3] && phase[2]) || (phase[1] && phase[0])) begin
            bad++;
            $display("FAIL shoot_through at cycle %0d: phase=%06b", cyc, phase);
        end
        for (int unsigned b = 0; b < 6; b++) begin
            if (phase[b] != prev_phase[b]) begin
                if (phase[b]) begin
                    total++;
                    if (cyc - last_chg[b] < DT) begin
                        bad++;
                        $display("FAIL deadtime gate %0d at cycle %0d: gap %0d want >= %0d",
                                 b, cyc, cyc - last_chg[b], DT);
                    end
                end
                last_chg[b] = cyc;
            end
        end
        prev_phase = phase;
    end

    int t0, tr, tf, code;
    int fwd_seq[5] = '{2, 6, 4, 5, 1};

    initial begin
        hall        = 3'b001;
        nfault      = 1'b1;
        enable      = 1'b0;
        dir         = 1'b0;
        pwm_in      = 1'b0;
        clear_fault = 1'b0;
        reset_n     = 1'b0;
        step(4);

        // Reset state
        chk("rst_phase", phase, 0);
        chk("rst_drv_en", drv_en, 0);
        chk("rst_sector", sector, 0);
        chk("rst_sector_valid", sector_valid, 0);
        chk("rst_hall_err", hall_err, 0);
        chk("rst_period", period, 0);
        chk("rst_period_valid", period_valid, 0);
        chk("rst_fault", fault_latched, 0);

        // Release: 001 on the pin becomes visible from this point
        reset_n = 1'b1;
        enable  = 1'b1;
        pwm_in  = 1'b1;
        mon_en  = 1'b1;
        t0      = cyc;
        model_apply(1, t0);
        step(1);
        chk("drv_en_on", drv_en, 1);
        while (cyc < t0 + DB + 3 + DT) step(1);
        chk("phase_in_dead", phase, 0);
        step(1);
        chk("first_turn_on", phase, 6'b100100);

        // Short glitch must not be accepted
        step(20);
        hall = 3'b011;
        step(5);
        hall = 3'b001;
        step(30);

        // Steady 011, then forward rotation with 1000-cycle spacing
        drive_hall(3);
        step(1000);
        foreach (fwd_seq[i]) begin
            drive_hall(fwd_seq[i]);
            step(1000);
        end

        // Reverse direction in sector 0 -> BH,AL
        dir = 1'b1;
        step(DT + 10);
        chk("dir_reverse", phase, 6'b011000);
        dir = 1'b0;
        step(DT + 10);
        chk("dir_forward", phase, 6'b100100);

        // PWM chop: turn-off immediate, turn-on after dead-time
        repeat (3) begin
            pwm_in = 1'b0;
            tf     = cyc;
            step(1);
            chk("pwm_fall", phase, 6'b000100);
            step(99);
            pwm_in = 1'b1;
            tr     = cyc;
            step(DT);
            chk("pwm_rise_early", phase, 6'b000100);
            step(1);
            chk("pwm_rise_on", phase, 6'b100100);
            step(100 - DT - 1);
        end

        // Illegal code, recovery, non-adjacent jump, saturated period
        drive_hall(7);
        step(DB + 3 + 5);
        chk("illegal_valid", sector_valid, 0);
        chk("illegal_phase", phase, 0);
        step(200);
        drive_hall(1);
        step(200);
        drive_hall(6);
        step(1100);
        drive_hall(4);
        step(200);

        // Fault handling in sector 4 (CH,AL)
        chk("pre_fault", phase, 6'b010010);
        nfault = 1'b0;
        tf     = cyc;
        step(1);
        nfault = 1'b1;
        step(1);
        chk("fault_not_yet", fault_latched, 0);
        step(1);
        chk("fault_phase", phase, 0);
        chk("fault_latch", fault_latched, 1);
        chk("fault_drv_en_lag", drv_en, 1);
        step(1);
        chk("fault_drv_en", drv_en, 0);
        step(10);
        chk("fault_sticky", fault_latched, 1);
        nfault = 1'b0;
        step(4);
        clear_fault = 1'b1;
        step(1);
        clear_fault = 1'b0;
        step(2);
        chk("clear_while_low", fault_latched, 1);
        nfault = 1'b1;
        step(4);
        clear_fault = 1'b1;
        step(1);
        clear_fault = 1'b0;
        chk("clear_ok", fault_latched, 0);
        step(1);
        chk("clear_drv_en", drv_en, 1);
        step(DT + 5);
        chk("post_clear_phase", phase, 6'b010010);

        // Randomised hall sequence with occasional sub-threshold glitches
        repeat (30) begin
            code   = $urandom_range(0, 7);
            dir    = 1'($urandom_range(0, 1));
            pwm_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0 && code != m_code) begin
                hall = 3'(code);
                step($urandom_range(1, DB - 1));
                hall = 3'(m_code);
                step(DB + 5);
            end else begin
                drive_hall(code);
                step($urandom_range(DB + 4, 400));
            end
        end

        step(DB + 10);
        chk("scoreboard_empty", sb.size(), 0);

        // Reset mid-operation
        mon_en  = 1'b0;
        reset_n = 1'b0;
        step(1);
        chk("mid_reset_phase", phase, 0);
        chk("mid_reset_valid", sector_valid, 0);
        chk("mid_reset_drv_en", drv_en, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
